// File: rtl/pic_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// pic_seq_ctrl_if
// Bundle of the signals between the instruction sequencer and its
// environment: the program-memory fetch handshake, the datapath
// strobes, interrupt signalling and the sequencer status outputs.
//
//   master : the sequencer (pic_seq_ctrl)
//            drives  rom_req, rom_addr, ir, exec_stb, wb_stb, irq_ack,
//                    gie, pc, stk_ovf, stk_unf
//            samples rom_ack, rom_data, skip_cond, irq, gie_wr, gie_wdata
//   slave  : program memory + datapath + interrupt source (the mirror view)
// -----------------------------------------------------------------------------
interface pic_seq_ctrl_if #(
    parameter int PC_W = 11
);
    // fetch handshake
    logic            rom_req;
    logic [PC_W-1:0] rom_addr;
    logic            rom_ack;
    logic [13:0]     rom_data;

    // datapath coupling
    logic [13:0]     ir;
    logic            exec_stb;
    logic            wb_stb;
    logic            skip_cond;
    logic            gie_wr;
    logic            gie_wdata;

    // interrupts
    logic            irq;
    logic            irq_ack;
    logic            gie;

    // status
    logic [PC_W-1:0] pc;
    logic            stk_ovf;
    logic            stk_unf;

    modport master (
        output rom_req, rom_addr, ir, exec_stb, wb_stb, irq_ack,
               gie, pc, stk_ovf, stk_unf,
        input  rom_ack, rom_data, skip_cond, irq, gie_wr, gie_wdata
    );

    modport slave (
        input  rom_req, rom_addr, ir, exec_stb, wb_stb, irq_ack,
               gie, pc, stk_ovf, stk_unf,
        output rom_ack, rom_data, skip_cond, irq, gie_wr, gie_wdata
    );
endinterface

// File: rtl/pic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pic_seq_ctrl
// Instruction sequencer for the multicycle PIC-style core. Owns the
// program counter, the fetch handshake towards program memory, the
// instruction register and a DEPTH-entry circular call/return stack.
// Handles GOTO / CALL / RETURN / RETFIE, conditional skip and a single
// interrupt vector. ALU and register file live in the datapath, which is
// told when to execute (exec_stb) and when to write back (wb_stb).
//
// Instruction flow: FETCH -> EXEC -> WB -> (IRQ | FETCH), IRQ -> FETCH.
// FETCH waits for rom_ack for as long as program memory needs.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bus        pic_seq_ctrl_if.master
//     rom_req/rom_addr/rom_ack/rom_data   fetch handshake
//     ir                                  current instruction word
//     exec_stb / wb_stb                   one-cycle datapath strobes
//     skip_cond                           sampled during exec_stb
//     gie_wr / gie_wdata                  GIE write, sampled during wb_stb
//     irq / irq_ack / gie                 level interrupt, entry pulse, enable
//     pc                                  program counter
//     stk_ovf / stk_unf                   sticky stack overflow / underflow
// -----------------------------------------------------------------------------
module pic_seq_ctrl #(
    parameter int              PC_W    = 11,
    parameter int              DEPTH   = 8,
    parameter logic [PC_W-1:0] IRQ_VEC = PC_W'('h004),
    parameter logic [PC_W-1:0] RST_VEC = PC_W'('h000)
) (
    input  logic          clk,
    input  logic          rst,
    pic_seq_ctrl_if.master bus
);

    localparam int              SP_W     = $clog2(DEPTH);
    localparam int              CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [13:0]     OP_RETURN = 14'h0008;
    localparam logic [13:0]     OP_RETFIE = 14'h0009;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2,
        S_IRQ   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t            state_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [13:0]       ir_reg;
    logic [SP_W-1:0]   sp_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              gie_reg;
    logic              stk_ovf_reg;
    logic              stk_unf_reg;
    logic              fetch_reg;     // high exactly while in S_FETCH
    logic              exec_stb_reg;
    logic              wb_stb_reg;
    logic              irq_ack_reg;

    // Call stack storage. Not reset: only entries written since the last
    // push are meaningful, sp/count carry the bookkeeping.
    logic [PC_W-1:0]   stack_mem [DEPTH];

    // -------------------------------------------------------------------------
    // Decode of the current instruction
    // -------------------------------------------------------------------------
    logic            is_goto;
    logic            is_call;
    logic            is_return;
    logic            is_retfie;
    logic [PC_W-1:0] jump_target;

    assign is_goto   = (ir_reg[13:11] == 3'b101);
    assign is_call   = (ir_reg[13:11] == 3'b100);
    assign is_return = (ir_reg == OP_RETURN);
    assign is_retfie = (ir_reg == OP_RETFIE);

    // Jumps replace the low 11 bits and keep the current page bits above.
    generate
        if (PC_W > 11) begin : g_paged_target
            assign jump_target = {pc_reg[PC_W-1:11], ir_reg[10:0]};
        end else begin : g_flat_target
            assign jump_target = ir_reg[10:0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stack access. Both push sources (CALL in EXEC, interrupt entry in IRQ)
    // save the current pc, and a pop only happens in EXEC, so at most one
    // stack operation occurs per cycle.
    // -------------------------------------------------------------------------
    logic            push_en;
    logic            pop_en;
    logic [SP_W-1:0] sp_dec;
    logic [PC_W-1:0] pop_data;

    assign push_en  = ((state_reg == S_EXEC) && is_call) || (state_reg == S_IRQ);
    assign pop_en   = (state_reg == S_EXEC) && (is_return || is_retfie);
    assign sp_dec   = sp_reg - 1'b1;
    // Popped value is needed in the same cycle as the pc update, so the
    // stack is read asynchronously.
    assign pop_data = stack_mem[sp_dec];

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[sp_reg] <= pc_reg;
        end
    end

    // GIE as seen by the interrupt decision: includes this cycle's write.
    logic gie_after_wb;
    assign gie_after_wb = bus.gie_wr ? bus.gie_wdata : gie_reg;

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            pc_reg       <= RST_VEC;
            ir_reg       <= '0;
            sp_reg       <= '0;
            count_reg    <= '0;
            gie_reg      <= 1'b0;
            stk_ovf_reg  <= 1'b0;
            stk_unf_reg  <= 1'b0;
            fetch_reg    <= 1'b1;
            exec_stb_reg <= 1'b0;
            wb_stb_reg   <= 1'b0;
            irq_ack_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (bus.rom_ack) begin
                        ir_reg       <= bus.rom_data;
                        pc_reg       <= pc_reg + 1'b1;
                        fetch_reg    <= 1'b0;
                        exec_stb_reg <= 1'b1;
                        state_reg    <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    exec_stb_reg <= 1'b0;
                    wb_stb_reg   <= 1'b1;
                    state_reg    <= S_WB;
                    if (is_goto || is_call) begin
                        pc_reg <= jump_target;
                    end else if (is_return) begin
                        pc_reg <= pop_data;
                    end else if (is_retfie) begin
                        pc_reg  <= pop_data;
                        gie_reg <= 1'b1;
                    end else if (bus.skip_cond) begin
                        // Step over the next word without fetching it.
                        pc_reg <= pc_reg + 1'b1;
                    end
                end

                S_WB: begin
                    wb_stb_reg <= 1'b0;
                    if (bus.gie_wr) begin
                        gie_reg <= bus.gie_wdata;
                    end
                    if (bus.irq && gie_after_wb) begin
                        irq_ack_reg <= 1'b1;
                        state_reg   <= S_IRQ;
                    end else begin
                        fetch_reg <= 1'b1;
                        state_reg <= S_FETCH;
                    end
                end

                S_IRQ: begin
                    // Clearing gie masks the still-asserted level irq until
                    // software re-enables it (normally via RETFIE).
                    pc_reg      <= IRQ_VEC;
                    gie_reg     <= 1'b0;
                    irq_ack_reg <= 1'b0;
                    fetch_reg   <= 1'b1;
                    state_reg   <= S_FETCH;
                end

                default: begin
                    fetch_reg <= 1'b1;
                    state_reg <= S_FETCH;
                end
            endcase

            // Stack pointer / occupancy bookkeeping.
            if (push_en) begin
                sp_reg <= sp_reg + 1'b1;
                if (count_reg == CNT_FULL) begin
                    // Full: the oldest entry has just been overwritten.
                    stk_ovf_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else if (pop_en) begin
                sp_reg <= sp_dec;
                if (count_reg == '0) begin
                    // Empty: the wrapped entry is returned anyway.
                    stk_unf_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg - 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // fetch_reg resets to 1 so the first fetch starts right after reset is
    // released; gating with rst keeps the request low while reset is held.
    assign bus.rom_req  = fetch_reg & ~rst;
    assign bus.rom_addr = pc_reg;
    assign bus.ir       = ir_reg;
    assign bus.exec_stb = exec_stb_reg;
    assign bus.wb_stb   = wb_stb_reg;
    assign bus.irq_ack  = irq_ack_reg;
    assign bus.gie      = gie_reg;
    assign bus.pc       = pc_reg;
    assign bus.stk_ovf  = stk_ovf_reg;
    assign bus.stk_unf  = stk_unf_reg;

endmodule

// File: tb/tb_pic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pic_seq_ctrl
// Self-checking bench for pic_seq_ctrl (PC_W=11, DEPTH=8). The bench plays
// program memory and datapath, one instruction per call of run_instr, and
// keeps an instruction-level reference model (pc, gie, stack, flags).
// -----------------------------------------------------------------------------
module tb_pic_seq_ctrl;

    localparam int          PCW   = 11;
    localparam int          DEPTH = 8;
    localparam logic [10:0] IVEC  = 11'h004;

    logic clk;
    logic rst;

    pic_seq_ctrl_if #(.PC_W(PCW)) bus ();

    pic_seq_ctrl #(
        .PC_W   (PCW),
        .DEPTH  (DEPTH),
        .IRQ_VEC(IVEC),
        .RST_VEC(11'h000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int test_cnt = 0;
    int fail_cnt = 0;

    // Reference model state
    logic [10:0] m_pc;
    logic        m_gie;
    logic        m_ovf;
    logic        m_unf;
    logic [10:0] m_stk [DEPTH];
    int          m_sp;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_push(input logic [10:0] v);
        m_stk[m_sp] = v;
        m_sp = (m_sp + 1) % DEPTH;
        if (m_cnt == DEPTH) m_ovf = 1'b1;
        else m_cnt++;
    endtask

    task automatic m_pop(output logic [10:0] v);
        m_sp = (m_sp + DEPTH - 1) % DEPTH;
        v = m_stk[m_sp];
        if (m_cnt == 0) m_unf = 1'b1;
        else m_cnt--;
    endtask

    task automatic m_reset();
        m_pc  = 11'h000;
        m_gie = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_sp  = 0;
        m_cnt = 0;
    endtask

    // Assert reset at a negative edge, hold one cycle, release.
    task automatic do_reset();
        rst = 1'b1;
        bus.rom_ack = 1'b0;
        bus.skip_cond = 1'b0;
        bus.gie_wr = 1'b0;
        bus.irq = 1'b0;
        #1;
        check("rst_req_low", bus.rom_req, 1'b0);
        check("rst_pc", bus.pc, 11'h000);
        check("rst_exec_low", bus.exec_stb, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_reset();
        check("post_rst_req", bus.rom_req, 1'b1);
        check("post_rst_addr", bus.rom_addr, 11'h000);
        check("post_rst_gie", bus.gie, 1'b0);
        check("post_rst_ovf", bus.stk_ovf, 1'b0);
        check("post_rst_unf", bus.stk_unf, 1'b0);
        $display("[TB] reset: pc=%0h rom_req=%0b", bus.pc, bus.rom_req);
    endtask

    // One full instruction, starting while the sequencer sits in FETCH.
    task automatic run_instr(input logic [13:0] word, input int waits, input bit skip,
                             input bit gwr, input bit gwd, input bit irq_lvl);
        int          cyc;
        bit          exp_irq;
        logic [10:0] fetch_addr;
        logic [10:0] popped;
        cyc = 0;
        bus.irq = irq_lvl;
        fetch_addr = m_pc;
        check("fetch_req", bus.rom_req, 1'b1);
        check("fetch_addr", bus.rom_addr, m_pc);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            cyc++;
            check("wait_req", bus.rom_req, 1'b1);
            check("wait_no_exec", bus.exec_stb, 1'b0);
        end
        bus.rom_ack = 1'b1;
        bus.rom_data = word;
        @(negedge clk);
        cyc++;
        bus.rom_ack = 1'b0;
        bus.rom_data = 14'($urandom);
        // EXEC
        m_pc = m_pc + 11'd1;
        check("exec_stb", bus.exec_stb, 1'b1);
        check("ir", bus.ir, word);
        check("exec_pc", bus.pc, m_pc);
        check("exec_req_low", bus.rom_req, 1'b0);
        bus.skip_cond = skip;
        if (word[13:11] == 3'b101) begin
            m_pc = word[10:0];
        end else if (word[13:11] == 3'b100) begin
            m_push(m_pc);
            m_pc = word[10:0];
        end else if (word == 14'h0008) begin
            m_pop(popped);
            m_pc = popped;
        end else if (word == 14'h0009) begin
            m_pop(popped);
            m_pc = popped;
            m_gie = 1'b1;
        end else if (skip) begin
            m_pc = m_pc + 11'd1;
        end
        @(negedge clk);
        cyc++;
        bus.skip_cond = 1'b0;
        // WB
        check("wb_stb", bus.wb_stb, 1'b1);
        check("exec_once", bus.exec_stb, 1'b0);
        bus.gie_wr = gwr;
        bus.gie_wdata = gwd;
        if (gwr) m_gie = gwd;
        exp_irq = irq_lvl && m_gie;
        @(negedge clk);
        cyc++;
        bus.gie_wr = 1'b0;
        check("irq_ack", bus.irq_ack, exp_irq);
        check("wb_once", bus.wb_stb, 1'b0);
        if (exp_irq) begin
            m_push(m_pc);
            m_pc = IVEC;
            m_gie = 1'b0;
            @(negedge clk);
            cyc++;
            check("irq_ack_pulse", bus.irq_ack, 1'b0);
        end
        check("instr_cycles", cyc, waits + 3 + (exp_irq ? 1 : 0));
        check("next_pc", bus.pc, m_pc);
        check("gie", bus.gie, m_gie);
        check("stk_ovf", bus.stk_ovf, m_ovf);
        check("stk_unf", bus.stk_unf, m_unf);
        $display("[TB] instr @%03h word=%04h waits=%0d skip=%0b irq=%0b -> pc=%03h gie=%0b cyc=%0d",
                 fetch_addr, word, waits, skip, irq_lvl, bus.pc, bus.gie, cyc);
    endtask

    task automatic run_nop(input int n);
        for (int i = 0; i < n; i++) run_instr(14'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [13:0] w;
        int          kind;
        rst = 1'b1;
        bus.rom_ack = 1'b0;
        bus.rom_data = 14'h0000;
        bus.skip_cond = 1'b0;
        bus.irq = 1'b0;
        bus.gie_wr = 1'b0;
        bus.gie_wdata = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Slow fetch of a plain instruction: 3 wait states, 6 clocks total.
        run_instr(14'h3005, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("slow_fetch_next_addr", bus.rom_addr, 11'h001);

        // Reset in the middle of a fetch that never completes.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stalled_req", bus.rom_req, 1'b1);
        end
        do_reset();

        // CALL at 0x002 to 0x010, RETURN there, back to 0x003.
        run_nop(2);
        run_instr(14'h2010, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("call_target", bus.rom_addr, 11'h010);
        run_instr(14'h0008, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("return_addr", bus.rom_addr, 11'h003);
        check("call_ret_no_ovf", bus.stk_ovf, 1'b0);
        check("call_ret_no_unf", bus.stk_unf, 1'b0);

        // pc wrap at the top of program memory.
        run_instr(14'h2FFF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_nop(1);
        check("pc_wrap", bus.rom_addr, 11'h000);

        // Skip at 0x005 goes straight to 0x007.
        do_reset();
        run_nop(5);
        run_instr(14'h1234, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        check("skip_addr", bus.rom_addr, 11'h007);

        // Nine nested calls / nine returns with DEPTH=8.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            w = 14'h2000 | 14'(11'h100 + 11'(i * 16));
            run_instr(w, i % 2, 1'b0, 1'b0, 1'b0, 1'b0);
            check("ovf_progress", bus.stk_ovf, (i == 8) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 9; i++) begin
            run_instr(14'h0008, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("unf_progress", bus.stk_unf, (i == 8) ? 1'b1 : 1'b0);
        end

        // Interrupt entry at 0x020 and RETFIE back to 0x021.
        do_reset();
        run_instr(14'h2820, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("gie_set", bus.gie, 1'b1);
        run_instr(14'h0123, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("irq_vector", bus.rom_addr, 11'h004);
        check("irq_gie_cleared", bus.gie, 1'b0);
        run_instr(14'h0009, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("retfie_addr", bus.rom_addr, 11'h021);
        check("retfie_gie", bus.gie, 1'b1);

        // Randomized instruction stream against the reference model.
        do_reset();
        for (int n = 0; n < 250; n++) begin
            kind = int'($urandom_range(0, 9));
            w = 14'($urandom);
            if (kind <= 1) begin
                w = {3'b101, w[10:0]};
            end else if (kind == 2) begin
                w = {3'b100, w[10:0]};
            end else if (kind == 3 && m_cnt > 0) begin
                w = 14'h0008;
            end else if (kind == 4 && m_cnt > 0) begin
                w = 14'h0009;
            end else begin
                if (w[13:11] == 3'b100 || w[13:11] == 3'b101) w[13] = 1'b0;
                if (w == 14'h0008 || w == 14'h0009) w = w | 14'h0100;
            end
            run_instr(w, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
